// File: rtl/challenge_sequencer_if.sv
// ============================================================================
// Module   : challenge_sequencer_if
// Purpose  : Trigger/response handshake between the sequencer and the mapping stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface challenge_sequencer_if #(
    parameter int IN_WIDTH  = 128,
    parameter int OUT_WIDTH = 16
);
    logic                 mapTrigger;
    logic [IN_WIDTH-1:0]  mapChallenge;
    logic                 mapDone;
    logic [OUT_WIDTH-1:0] mapResponse;

    modport master (
        output mapTrigger,
        output mapChallenge,
        input  mapDone,
        input  mapResponse
    );

    modport slave (
        input  mapTrigger,
        input  mapChallenge,
        output mapDone,
        output mapResponse
    );
endinterface

`default_nettype wire

// File: rtl/challenge_sequencer.sv
// ============================================================================
// Module   : challenge_sequencer
// Purpose  : Issues NUM_CHAL LFSR-derived challenges to a mapping stage and
//            collects its responses, with a per-challenge timeout.
// Revision : 1.0
// ============================================================================
`default_nettype none

module challenge_sequencer #(
    parameter int IN_WIDTH  = 128,
    parameter int OUT_WIDTH = 16,
    parameter int NUM_CHAL  = 8,
    parameter int TIMEOUT   = 31
) (
    input  wire logic                          clk,
    input  wire logic                          reset,
    input  wire logic                          start,
    input  wire logic [IN_WIDTH-1:0]           seed,
    output logic                               busy,
    output logic                               done,
    output logic                               error,
    output logic [NUM_CHAL*OUT_WIDTH-1:0]      respBits,
    output logic [$clog2(NUM_CHAL)-1:0]        chalIdx,
    challenge_sequencer_if.master              map_if
);

    localparam int c_IDX_W = $clog2(NUM_CHAL);
    localparam int c_TMR_W = $clog2(TIMEOUT + 1);

    // Feedback taps for x^128+x^126+x^101+x^99+1, kept relative to the MSB
    localparam int c_TAP_A = IN_WIDTH - 1;
    localparam int c_TAP_B = IN_WIDTH - 3;
    localparam int c_TAP_C = IN_WIDTH - 28;
    localparam int c_TAP_D = IN_WIDTH - 30;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t                        r_state;
    logic [c_TMR_W-1:0]            r_timer;
    logic [c_IDX_W-1:0]            r_idx;
    logic [IN_WIDTH-1:0]           r_chal;
    logic [NUM_CHAL*OUT_WIDTH-1:0] r_resp;
    logic                          r_trig;
    logic                          r_done;
    logic                          r_error;

    logic                          w_fb;
    logic [IN_WIDTH-1:0]           w_chal_next;
    logic [IN_WIDTH-1:0]           w_seed_load;
    logic                          w_last;
    logic                          w_timeout;

    assign w_fb        = r_chal[c_TAP_A] ^ r_chal[c_TAP_B] ^ r_chal[c_TAP_C] ^ r_chal[c_TAP_D];
    assign w_chal_next = {r_chal[IN_WIDTH-2:0], w_fb};
    // An all-zero seed would lock the LFSR at zero
    assign w_seed_load = (seed == '0) ? IN_WIDTH'(1) : seed;
    assign w_last      = (r_idx == c_IDX_W'(NUM_CHAL - 1));
    assign w_timeout   = (r_timer == c_TMR_W'(TIMEOUT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_idx   <= '0;
            r_chal  <= '0;
            r_resp  <= '0;
            r_trig  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_trig <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_chal  <= w_seed_load;
                        r_idx   <= '0;
                        r_resp  <= '0;
                        r_error <= 1'b0;
                        r_trig  <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_timer <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // A response on the final timer cycle still counts as on time
                    if (map_if.mapDone) begin
                        r_resp[32'(r_idx) * OUT_WIDTH +: OUT_WIDTH] <= map_if.mapResponse;
                        r_chal <= w_chal_next;
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= S_FINISH;
                        end else begin
                            r_idx   <= r_idx + c_IDX_W'(1);
                            r_trig  <= 1'b1;
                            r_state <= S_ISSUE;
                        end
                    end else if (w_timeout) begin
                        r_error <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_FINISH;
                    end else begin
                        r_timer <= r_timer + c_TMR_W'(1);
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy                = (r_state != S_IDLE);
    assign done                = r_done;
    assign error               = r_error;
    assign respBits            = r_resp;
    assign chalIdx             = r_idx;
    assign map_if.mapTrigger   = r_trig;
    assign map_if.mapChallenge = r_chal;

endmodule

`default_nettype wire

// File: tb/tb_challenge_sequencer.sv
// ============================================================================
// Module   : tb_challenge_sequencer
// Purpose  : Directed bench for challenge_sequencer with a simple mapping-stage responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_challenge_sequencer;

    localparam int IW = 128;
    localparam int OW = 16;
    localparam int NC = 8;
    localparam int TO = 31;

    localparam logic [NC*OW-1:0] EXP_RESP =
        128'h8888_7777_6666_5555_4444_3333_2222_1111;

    logic              clk   = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [IW-1:0]     seed  = '0;
    logic              busy;
    logic              done;
    logic              error;
    logic [NC*OW-1:0]  respBits;
    logic [2:0]        chalIdx;

    challenge_sequencer_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) map_if ();

    challenge_sequencer #(
        .IN_WIDTH (IW),
        .OUT_WIDTH(OW),
        .NUM_CHAL (NC),
        .TIMEOUT  (TO)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .seed    (seed),
        .busy    (busy),
        .done    (done),
        .error   (error),
        .respBits(respBits),
        .chalIdx (chalIdx),
        .map_if  (map_if)
    );

    always #5 clk = ~clk;

    // Mapping-stage responder: answers m_delay cycles after each trigger (0 = never)
    int            m_delay = 17;
    int            m_cnt   = 0;
    bit            m_active = 1'b0;
    logic          m_done_r = 1'b0;
    int            m_trig  = 0;
    int            m_bad   = 0;
    logic [IW-1:0] m_chal [NC];
    logic [OW-1:0] m_resp  = '0;
    bit            inj_en  = 1'b0;
    logic          inj_done = 1'b0;

    assign map_if.mapDone     = m_done_r | inj_done;
    assign map_if.mapResponse = inj_done ? 16'hDEAD : m_resp;

    initial begin
        forever begin
            @(negedge clk);
            m_done_r = 1'b0;
            if (!reset) begin
                m_active = 1'b0;
                m_cnt    = 0;
            end else if (map_if.mapTrigger) begin
                if (m_active) m_bad++;
                if (m_trig < NC) m_chal[m_trig] = map_if.mapChallenge;
                m_resp   = OW'(32'h1111 * (m_trig + 1));
                m_trig++;
                m_active = (m_delay > 0);
                m_cnt    = m_delay;
            end else if (m_active) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_done_r = 1'b1;
                    m_active = 1'b0;
                end
            end
        end
    end

    int n_chk  = 0;
    int n_pass = 0;
    int busy_cyc;
    int done_cyc;
    bit hold_start = 1'b0;

    task automatic chk(input string tag, input logic [NC*OW-1:0] obs, input logic [NC*OW-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic start_run(input logic [IW-1:0] s);
        @(negedge clk);
        m_trig = 0;
        m_bad  = 0;
        for (int i = 0; i < NC; i++) m_chal[i] = '0;
        seed  = s;
        start = 1'b1;
    endtask

    task automatic run_to_idle(input int limit);
        busy_cyc = 0;
        done_cyc = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (!hold_start || done) start = 1'b0;
            inj_done = inj_en && map_if.mapTrigger;
            if (busy) busy_cyc++;
            if (done) done_cyc++;
            if (!busy) break;
        end
        inj_done = 1'b0;
    endtask

    initial begin
        int waits;
        int done_in_rst;

        // Reset state
        #12;
        chk("rst_busy",  busy, 0);
        chk("rst_done",  done, 0);
        chk("rst_error", error, 0);
        chk("rst_trig",  map_if.mapTrigger, 0);
        chk("rst_resp",  respBits, 0);
        chk("rst_chal",  map_if.mapChallenge, 0);
        chk("rst_idx",   chalIdx, 0);
        @(negedge clk) reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_no_start", busy, 0);

        // Scenario 1: seed=1, 17-cycle responder
        m_delay = 17;
        start_run(128'h1);
        run_to_idle(400);
        chk("s1_idle",     busy, 0);
        chk("s1_latency",  busy_cyc, 145);
        chk("s1_done_len", done_cyc, 1);
        chk("s1_error",    error, 0);
        chk("s1_resp",     respBits, EXP_RESP);
        chk("s1_chal0",    m_chal[0], 128'h1);
        chk("s1_chal1",    m_chal[1], 128'h2);
        chk("s1_chal7",    m_chal[7], 128'h80);
        chk("s1_trigs",    m_trig, 8);
        chk("s1_overlap",  m_bad, 0);
        chk("s1_idx",      chalIdx, 7);

        // Stray mapDone in IDLE
        @(negedge clk) inj_done = 1'b1;
        @(negedge clk) inj_done = 1'b0;
        chk("idle_stray_resp", respBits, EXP_RESP);
        chk("idle_stray_busy", busy, 0);

        // Scenario 2: seed=0 behaves like seed=1
        start_run(128'h0);
        run_to_idle(400);
        chk("s2_chal0",   m_chal[0], 128'h1);
        chk("s2_chal1",   m_chal[1], 128'h2);
        chk("s2_resp",    respBits, EXP_RESP);
        chk("s2_latency", busy_cyc, 145);

        // Scenario 3: responder silent -> timeout
        m_delay = 0;
        start_run(128'h1);
        run_to_idle(200);
        chk("s3_idle",     busy, 0);
        chk("s3_latency",  busy_cyc, 34);
        chk("s3_done_len", done_cyc, 1);
        chk("s3_error",    error, 1);
        chk("s3_idx",      chalIdx, 0);
        chk("s3_resp",     respBits, 0);
        chk("s3_trigs",    m_trig, 1);
        repeat (3) @(negedge clk);
        chk("s3_error_hold", error, 1);

        // Scenario 4: start held high, mapDone injected in every ISSUE cycle
        m_delay    = 17;
        hold_start = 1'b1;
        inj_en     = 1'b1;
        start_run(128'h1);
        run_to_idle(400);
        hold_start = 1'b0;
        inj_en     = 1'b0;
        chk("s4_latency",  busy_cyc, 145);
        chk("s4_done_len", done_cyc, 1);
        chk("s4_error",    error, 0);
        chk("s4_resp",     respBits, EXP_RESP);
        chk("s4_trigs",    m_trig, 8);
        repeat (2) @(negedge clk);
        chk("s4_no_restart", busy, 0);

        // Scenario 5: reset during WAIT of challenge 3
        start_run(128'h1);
        waits = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (chalIdx == 3'd3 && busy && !map_if.mapTrigger) waits++;
            if (waits == 5) break;
        end
        chk("s5_reached", chalIdx, 3);
        #2 reset = 1'b0;
        #1;
        chk("s5_busy",  busy, 0);
        chk("s5_done",  done, 0);
        chk("s5_error", error, 0);
        chk("s5_trig",  map_if.mapTrigger, 0);
        chk("s5_resp",  respBits, 0);
        chk("s5_chal",  map_if.mapChallenge, 0);
        chk("s5_idx",   chalIdx, 0);
        done_in_rst = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) done_in_rst++;
        end
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done) done_in_rst++;
        end
        chk("s5_no_done",  done_in_rst, 0);
        chk("s5_wait_idle", busy, 0);
        start_run(128'h1);
        run_to_idle(400);
        chk("s5_rerun_resp",    respBits, EXP_RESP);
        chk("s5_rerun_latency", busy_cyc, 145);

        // Scenario 6: mapDone on the timer==TIMEOUT cycle; seed exercises feedback
        m_delay = 32;
        start_run({1'b1, 126'h0, 1'b1});
        run_to_idle(600);
        chk("s6_error",   error, 0);
        chk("s6_latency", busy_cyc, 265);
        chk("s6_resp",    respBits, EXP_RESP);
        chk("s6_chal1",   m_chal[1], 128'h3);
        chk("s6_trigs",   m_trig, 8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/challenge_sequencer.md
CHALLENGE_SEQUENCER -- requirements
Module: challenge_sequencer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- IN_WIDTH, 128, challenge width.
- OUT_WIDTH, 16, response width.
- NUM_CHAL, 8, challenges per run.
- TIMEOUT, 31, maximum wait cycles per challenge.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on the rising edge.
- reset, in, 1, asynchronous active-low reset.
- start, in, 1, begins a run when sampled high in IDLE.
- seed, in, IN_WIDTH, initial challenge, sampled with start.
- busy, out, 1, high in every state except IDLE.
- done, out, 1, one-cycle pulse at end of run.
- error, out, 1, set on timeout; held until next accepted start.
- respBits, out, NUM_CHAL*OUT_WIDTH, collected responses.
- mapTrigger, out, 1, one-cycle trigger to the downstream mapping stage.
- mapChallenge, out, IN_WIDTH, challenge driven to the mapping stage.
- mapDone, in, 1, completion pulse from the mapping stage.
- mapResponse, in, OUT_WIDTH, response; valid when mapDone=1.
- chalIdx, out, clog2(NUM_CHAL), index of the current challenge.

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, WAIT and FINISH, plus a registered wait timer of clog2(TIMEOUT+1) bits.

REQ-004 In IDLE with start=1, the block SHALL:
- load mapChallenge with seed, or with IN_WIDTH'h1 if seed is 0;
- set chalIdx=0, respBits=0 and error=0;
- go to ISSUE.

REQ-005 In IDLE with start=0, the block SHALL hold all registers.

REQ-006 In ISSUE, the block SHALL drive mapTrigger=1 for exactly that one cycle, clear the timer and go to WAIT.

REQ-007 mapTrigger SHALL be registered and SHALL be 0 in every state other than ISSUE.

REQ-008 mapChallenge SHALL be stable from the ISSUE cycle until mapDone is accepted, so the mapping stage samples a constant challenge.

REQ-009 In WAIT, the timer SHALL increment by one each cycle mapDone=0.

REQ-010 In WAIT with mapDone=1, the block SHALL, in the same edge:
- write mapResponse into respBits[chalIdx*OUT_WIDTH +: OUT_WIDTH];
- advance mapChallenge one LFSR step;
- if chalIdx==NUM_CHAL-1, go to FINISH, else increment chalIdx and go to ISSUE.

REQ-011 In WAIT with mapDone=0 and timer==TIMEOUT, the block SHALL set error=1, leave respBits and chalIdx unchanged and go to FINISH.

REQ-012 If mapDone=1 and timer==TIMEOUT in the same cycle, mapDone SHALL win: the response is stored and error stays 0.

REQ-013 The LFSR step SHALL be a Fibonacci shift left, x^128+x^126+x^101+x^99+1: new={chal[IN_WIDTH-2:0], chal[127]^chal[125]^chal[100]^chal[98]}.

REQ-014 In FINISH, done SHALL be 1 for exactly one cycle and the FSM SHALL then return to IDLE.

REQ-015 respBits and error SHALL hold their values in IDLE until the next accepted start.

REQ-016 start SHALL be ignored whenever busy=1, with no restart and no reload.

REQ-017 mapDone SHALL be ignored in IDLE, ISSUE and FINISH; a stray pulse there SHALL have no effect.

REQ-018 There SHALL be exactly one mapTrigger per challenge, and no new trigger while the mapping stage is computing.

REQ-019 Run latency SHALL be 1 (IDLE) + sum over challenges of (1 ISSUE + k_i WAIT cycles) + 1 (FINISH), where k_i is the number of WAIT cycles up to and including the cycle in which mapDone is accepted.

Reset
REQ-020 While reset=0, asynchronously and independent of clk, the block SHALL force:
- state=IDLE;
- busy=0, done=0, error=0, mapTrigger=0;
- respBits=0, mapChallenge=0, chalIdx=0, timer=0.

REQ-021 Assertion of reset mid-run SHALL abort the run immediately, with no done pulse.

REQ-022 After reset deasserts, the block SHALL wait for a fresh start.

Verification
REQ-023 The bench SHALL cover these directed scenarios (stimulus -> required response):
1. seed=1, start pulse, mapping model answers 0x1111*(i+1) 17 cycles after each trigger -> mapChallenge for challenge 0 is 0x...01 and for challenge 1 is 0x...02; 8 triggers; respBits[15:0]=0x1111, respBits[127:112]=0x8888; done one cycle; error=0.
2. seed=0 -> first mapChallenge is 0x...01, identical to scenario 1.
3. Model never asserts mapDone -> after TIMEOUT wait cycles: error=1, done pulse, chalIdx=0, respBits=0, only one trigger issued.
4. start held high throughout a run, plus a mapDone pulse injected in ISSUE -> no restart and no extra respBits write; run completes as in scenario 1.
5. reset=0 asserted during WAIT of challenge 3 -> all outputs 0 within the same cycle, no done; a new start then runs normally.
6. mapDone arrives on exactly the cycle timer==TIMEOUT -> response stored, error=0, run continues.
